// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        WRITE,
        CHK,
        START
    } state_t;

    localparam int unsigned CHK_W = 8;

    function automatic int unsigned bytes_per_word(input int unsigned word_w);
        return word_w / 8;
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Shifts stream bytes MSB-first into a word register and tracks the byte position.
module word_assembler
    import loader_pkg::*;
#(
    parameter int unsigned WORD_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              load,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word_out,
    output logic              word_full
);

    localparam int unsigned BPW = bytes_per_word(WORD_W);

    logic [2:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;

    // word_full flags the load that completes the word; the count wraps on that load.
    always_comb begin
        cnt_d     = cnt_q;
        word_d    = word_q;
        word_full = load && (cnt_q == 3'(BPW - 1));
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            word_d = (word_q << 8) | WORD_W'(byte_in);
            cnt_d  = word_full ? 3'd0 : cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word_out = word_q;

endmodule

// File: rtl/program_loader.sv
// Receives a framed byte stream, writes assembled words to instruction memory,
// verifies the checksum and then launches the computer with a start pulse.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              start,
    output logic              busy,
    output logic              err
);

    state_t            state_q, state_d;
    logic [7:0]        n_q, n_d;
    logic [ADDR_W-1:0] wcnt_q, wcnt_d;
    logic [CHK_W-1:0]  sum_q, sum_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;

    logic              asm_load, asm_clr, word_full, accept;
    logic [WORD_W-1:0] word;

    assign accept = rx_valid && rx_ready;

    word_assembler #(
        .WORD_W (WORD_W)
    ) u_word_assembler (
        .clk       (clk),
        .reset     (reset),
        .clr       (asm_clr),
        .load      (asm_load),
        .byte_in   (rx_data),
        .word_out  (word),
        .word_full (word_full)
    );

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        wcnt_d    = wcnt_q;
        sum_d     = sum_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        asm_load  = 1'b0;
        asm_clr   = 1'b0;
        rx_ready  = 1'b0;
        mem_we    = 1'b0;
        start     = 1'b0;
        busy      = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        // rx_ready is gated by reset so it reads 0 while reset is held.
        unique case (state_q)
            IDLE: begin
                rx_ready = reset;
                if (accept) begin
                    n_d     = rx_data;
                    wcnt_d  = '0;
                    sum_d   = '0;
                    err_d   = 1'b0;
                    asm_clr = 1'b1;
                    state_d = (rx_data == 8'd0) ? CHK : DATA;
                end
            end
            DATA: begin
                rx_ready = reset;
                busy     = 1'b1;
                if (accept) begin
                    asm_load = 1'b1;
                    sum_d    = sum_q + rx_data;
                    if (word_full) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wcnt_q;
                mem_wdata = word;
                addr_d    = wcnt_q;
                wdata_d   = word;
                wcnt_d    = wcnt_q + 1'b1;
                state_d   = (wcnt_q + 1'b1 == ADDR_W'(n_q)) ? CHK : DATA;
            end
            CHK: begin
                rx_ready = reset;
                busy     = 1'b1;
                if (accept) begin
                    if (rx_data == sum_q) begin
                        state_d = START;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            START: begin
                start   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            wcnt_q  <= '0;
            sum_q   <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            wcnt_q  <= wcnt_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign err = err_q;

endmodule
